// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped I/O peripheral for CPU accesses with addr[7]=1.
//   Debounces btnL/btnR, latches the switches on a btnR press and holds the LED register.
// Latency: button to event is 2 sync + DEBOUNCE_CYCLES + 1 cycles; read_data is combinational.
// Backpressure: none. Every access completes in one cycle, and the CPU polls the sticky flags.
// Ports:
//   clk, reset        : single clock; synchronous active-low reset
//   read_en, write_en : peripheral read select / qualified write strobe
//   addr              : register select (00 status, 01 switches, 10 LED, 11 reserved)
//   write_data        : store data; read_data : load data, 0 when read_en=0
//   btnL, btnR        : raw buttons ("output request" / "input ready")
//   switch            : raw switches; led : LED/display register
module io_port_ctrl #(
   parameter int unsigned      CNT_W           = 16,
   parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read_en,
   input  logic        write_en,
   input  logic [1:0]  addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   input  logic        btnL,
   input  logic        btnR,
   input  logic [15:0] switch,
   output logic [11:0] led
);

   localparam logic [CNT_W-1:0] CNT_MAX = DEBOUNCE_CYCLES - CNT_W'(1);

   localparam logic [1:0] ADDR_STATUS = 2'b00;
   localparam logic [1:0] ADDR_SWITCH = 2'b01;
   localparam logic [1:0] ADDR_LED    = 2'b10;

   // Index 0 is btnL, index 1 is btnR.
   logic [1:0]            btn_raw;
   logic [1:0]            btn_s1_q, btn_s2_q;
   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]            db_q, db_d;
   logic [1:0]            db_prev_q;
   logic [1:0]            btn_evt;

   logic [15:0] sw_s1_q, sw_s2_q;
   logic [15:0] sw_latch_q, sw_latch_d;
   logic        sw_ready_q, sw_ready_d;
   logic        led_ready_q, led_ready_d;
   logic [11:0] led_q, led_d;

   logic        wr_led;
   logic        rd_sw;
   logic        wdata_unused;

   assign btn_raw = {btnR, btnL};

   // The event fires in the cycle after the debounced level rises.
   assign btn_evt = db_q & ~db_prev_q;

   assign wr_led = write_en && (addr == ADDR_LED);
   assign rd_sw  = read_en  && (addr == ADDR_SWITCH);

   // Only the low 12 bits of an LED write are stored.
   assign wdata_unused = ^write_data[31:12];

   // Debounce: count consecutive cycles where the synced input disagrees
   // with the debounced level; any agreement restarts the count.
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      for (int i = 0; i < 2; i++) begin
         if (btn_s2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            db_d[i]  = btn_s2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Sticky flags: when a button event coincides with its clear, the set wins.
   always_comb begin
      sw_latch_d  = sw_latch_q;
      sw_ready_d  = sw_ready_q;
      led_d       = led_q;
      led_ready_d = led_ready_q;

      if (rd_sw) begin
         sw_ready_d = 1'b0;
      end
      if (btn_evt[1]) begin
         sw_latch_d = sw_s2_q;
         sw_ready_d = 1'b1;
      end

      if (wr_led) begin
         led_d       = write_data[11:0];
         led_ready_d = 1'b0;
      end
      if (btn_evt[0]) begin
         led_ready_d = 1'b1;
      end
   end

   // Read mux shows pre-edge state, even when a write to the same address is in flight.
   always_comb begin
      read_data = '0;
      if (read_en) begin
         case (addr)
            ADDR_STATUS: read_data = {30'b0, led_ready_q, sw_ready_q};
            ADDR_SWITCH: read_data = {16'b0, sw_latch_q};
            ADDR_LED:    read_data = {20'b0, led_q};
            default:     read_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         btn_s1_q    <= '0;
         btn_s2_q    <= '0;
         sw_s1_q     <= '0;
         sw_s2_q     <= '0;
         cnt_q       <= '0;
         db_q        <= '0;
         db_prev_q   <= '0;
         sw_latch_q  <= '0;
         sw_ready_q  <= 1'b0;
         led_ready_q <= 1'b0;
         led_q       <= '0;
      end else begin
         btn_s1_q    <= btn_raw;
         btn_s2_q    <= btn_s1_q;
         sw_s1_q     <= switch;
         sw_s2_q     <= sw_s1_q;
         cnt_q       <= cnt_d;
         db_q        <= db_d;
         db_prev_q   <= db_q;
         sw_latch_q  <= sw_latch_d;
         sw_ready_q  <= sw_ready_d;
         led_ready_q <= led_ready_d;
         led_q       <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed and random checks of io_port_ctrl against a behavioural model.
// Latency: the model advances once per rising edge; outputs are sampled 1-2 time units after it.
// Backpressure: not applicable; the bench drives every input on every cycle.
module tb_io_port_ctrl;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        read_en;
   logic        write_en;
   logic [1:0]  addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        btnL;
   logic        btnR;
   logic [15:0] switch;
   logic [11:0] led;

   always #5 clk = ~clk;

   io_port_ctrl #(
      .CNT_W          (16),
      .DEBOUNCE_CYCLES(16'd4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .read_en   (read_en),
      .write_en  (write_en),
      .addr      (addr),
      .write_data(write_data),
      .read_data (read_data),
      .btnL      (btnL),
      .btnR      (btnR),
      .switch    (switch),
      .led       (led)
   );

   int cmp_cnt = 0;
   int err_cnt = 0;

   // Behavioural model: synchronisers as 2-deep delay queues, debounce as
   // "D consecutive disagreeing samples flip the level".
   bit          qL[$];
   bit          qR[$];
   logic [15:0] qS[$];
   int          lvlL = 0, lvlR = 0, runL = 0, runR = 0;
   bit          evL = 0, evR = 0;
   logic [15:0] m_latch = '0;
   bit          m_swr = 0, m_ledr = 0;
   logic [11:0] m_led = '0;

   function automatic logic [31:0] m_read(input logic en, input logic [1:0] a);
      if (!en) return 32'h0;
      case (a)
         2'd0:    return {30'b0, m_ledr, m_swr};
         2'd1:    return {16'b0, m_latch};
         2'd2:    return {20'b0, m_led};
         default: return 32'h0;
      endcase
   endfunction

   task automatic db_step(input bit smp, inout int lvl, inout int run, output bit rise);
      rise = 0;
      if (int'(smp) != lvl) begin
         run++;
         if (run == D) begin
            lvl  = int'(smp);
            run  = 0;
            rise = (lvl == 1);
         end
      end else begin
         run = 0;
      end
   endtask

   task automatic model_edge();
      bit rl, rr;
      if (!reset) begin
         qL = {}; qR = {}; qS = {};
         qL.push_back(1'b0); qL.push_back(1'b0);
         qR.push_back(1'b0); qR.push_back(1'b0);
         qS.push_back(16'h0); qS.push_back(16'h0);
         lvlL = 0; lvlR = 0; runL = 0; runR = 0;
         evL = 0; evR = 0;
         m_latch = '0; m_swr = 0; m_ledr = 0; m_led = '0;
         return;
      end
      if (evR) begin
         m_latch = qS[0];
         m_swr   = 1;
      end else if (read_en && addr == 2'd1) begin
         m_swr = 0;
      end
      if (write_en && addr == 2'd2) m_led = write_data[11:0];
      if (evL) m_ledr = 1;
      else if (write_en && addr == 2'd2) m_ledr = 0;
      db_step(qL[0], lvlL, runL, rl);
      db_step(qR[0], lvlR, runR, rr);
      evL = rl;
      evR = rr;
      qL.push_back(btnL);   void'(qL.pop_front());
      qR.push_back(btnR);   void'(qR.pop_front());
      qS.push_back(switch); void'(qS.pop_front());
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Combinational read with a constant expectation and a model cross-check.
   task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
      read_en  = 1'b1;
      write_en = 1'b0;
      addr     = a;
      #1;
      check(tag, read_data, exp);
      check({tag, "_model"}, read_data, m_read(1'b1, a));
   endtask

   initial begin
      logic [15:0] nv;
      logic [31:0] wv;

      reset = 1'b0; read_en = 1'b0; write_en = 1'b0; addr = 2'd0;
      write_data = '0; btnL = 1'b0; btnR = 1'b0; switch = '0;

      // Reset state
      repeat (3) tick();
      reset = 1'b1;
      #1;
      check("rst_led", {20'b0, led}, 32'h0);
      for (int a = 0; a < 4; a++) rd(2'(a), "rst_rd", 32'h0);

      // Switch handshake: sw_ready appears 7 edges after the raw rise
      read_en = 1'b0;
      switch  = 16'hA5C3;
      tick(); tick();
      btnR = 1'b1; read_en = 1'b1; addr = 2'd0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 6) check("t2_not_yet", read_data, 32'h0);
         if (i == 7) check("t2_ready", read_data, 32'h1);
      end
      btnR = 1'b0;
      rd(2'd0, "t2_status", 32'h1);
      rd(2'd1, "t2_switch", 32'h0000A5C3);
      tick();
      rd(2'd0, "t2_cleared", 32'h0);
      read_en = 1'b0;
      repeat (8) tick();

      // Bounce rejection, then one clean press
      read_en = 1'b1; addr = 2'd0;
      for (int i = 0; i < 20; i++) begin
         btnR = ((i % 3) != 2);
         tick();
         check("t3_bounce", read_data, m_read(1'b1, 2'd0));
      end
      btnR = 1'b0;
      repeat (8) tick();
      check("t3_no_event", read_data, 32'h0);
      btnR = 1'b1;
      repeat (6) tick();
      btnR = 1'b0;
      repeat (10) tick();
      check("t3_one_event", read_data, 32'h1);
      addr = 2'd1;
      tick();
      addr = 2'd0;
      repeat (10) tick();
      check("t3_single", read_data, 32'h0);

      // LED handshake
      btnL = 1'b1;
      repeat (8) tick();
      btnL = 1'b0;
      repeat (8) tick();
      rd(2'd0, "t4_status", 32'h2);
      read_en = 1'b0; write_en = 1'b1; addr = 2'd2; write_data = 32'hFFFF_F7E1;
      tick();
      write_en = 1'b0;
      check("t4_led", {20'b0, led}, 32'h7E1);
      rd(2'd0, "t4_status_clr", 32'h0);
      rd(2'd2, "t4_led_rd", 32'h7E1);

      // Collision: btnR event with a switch-data read on the same edge
      nv = 16'($urandom);
      if (nv == 16'hA5C3) nv = 16'h5A3C;
      read_en = 1'b0; switch = nv;
      tick(); tick();
      btnR = 1'b1;
      repeat (6) tick();
      read_en = 1'b1; addr = 2'd1;
      #1;
      check("t5_pre_edge", read_data, 32'h0000A5C3);
      tick();
      rd(2'd0, "t5_ready_kept", 32'h1);
      rd(2'd1, "t5_new_latch", {16'b0, nv});
      read_en = 1'b0; btnR = 1'b0;
      repeat (8) tick();

      // Collision: btnL event with an LED write on the same edge
      btnL = 1'b1;
      repeat (6) tick();
      wv = $urandom;
      write_en = 1'b1; addr = 2'd2; write_data = wv;
      tick();
      write_en = 1'b0;
      check("t5_led_upd", {20'b0, led}, {20'b0, wv[11:0]});
      rd(2'd0, "t5_led_ready_kept", 32'h3);
      read_en = 1'b0; btnL = 1'b0;
      repeat (8) tick();

      // Reset mid-debounce with btnL held through release
      btnL = 1'b1;
      repeat (4) tick();
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      read_en = 1'b1; addr = 2'd0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 6) check("t6_not_yet", read_data, 32'h0);
         if (i == 7) check("t6_event", read_data, 32'h2);
      end
      check("t6_led", {20'b0, led}, 32'h0);
      repeat (10) tick();
      check("t6_single", read_data, 32'h2);
      btnL = 1'b0;
      repeat (8) tick();

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) btnL = ~btnL;
         if ($urandom_range(0, 4) == 0) btnR = ~btnR;
         switch     = 16'($urandom);
         read_en    = 1'($urandom_range(0, 1));
         addr       = 2'($urandom_range(0, 3));
         write_en   = ($urandom_range(0, 3) == 0);
         write_data = $urandom;
         reset      = ($urandom_range(0, 99) != 0);
         #1;
         check("rnd_read", read_data, m_read(read_en, addr));
         tick();
         check("rnd_led", {20'b0, led}, {20'b0, m_led});
      end
      reset = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
